// File: rtl/cache_bus_pkg.sv
// Shared types and constants for the CPU<->cache bus arbiter and its round-robin helper.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    R8  = 3'd1,
    R16 = 3'd2,
    R32 = 3'd3,
    INV = 3'd4,
    W8  = 3'd5,
    W16 = 3'd6,
    W32 = 3'd7
  } cmd_t;

  localparam logic [2:0] C1_RESPONSE       = 3'd7;
  localparam int         CACHE_LINE_SIZE   = 32;
  localparam int         CACHE_OFFSET_SIZE = $clog2(CACHE_LINE_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_ADDR2,
    ST_TURN,
    ST_WAIT_RSP,
    ST_RSP_HI
  } state_t;

  function automatic logic is_write(input cmd_t c);
    return (c == W8) || (c == W16) || (c == W32);
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, pointer favours the requester not served last.
module bus_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr_reg ? 2'b10 : 2'b01;
  end

  // Pointer moves to the other requester after every grant, even uncontested ones.
  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= 1'b0;
    else if (advance && |req) ptr_reg <= grant[0];
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares the C1/A1/D1 cache bus between two requesters: two-phase address,
// turnaround, response wait with timeout, and a one-cycle done/rdata strobe.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int OFFSET_W = CACHE_OFFSET_SIZE,
  parameter int A1_W     = 15,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  cmd_t              cmd0,
  input  cmd_t              cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic [1:0]        done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [A1_W-1:0]   a1,
  output logic [2:0]        c1_out,
  output logic              c1_oe,
  input  logic [2:0]        c1_in,
  output logic [15:0]       d1_out,
  output logic              d1_oe,
  input  logic [15:0]       d1_in
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  state_t              state_reg;
  logic [1:0]          grant;
  logic                owner_reg;
  cmd_t                cmd_reg;
  logic [OFFSET_W-1:0] offset_reg;
  logic [15:0]         wdata_hi_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [1:0]          owner_done;

  cmd_t                sel_cmd;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;

  assign sel_cmd    = grant[1] ? cmd1   : cmd0;
  assign sel_addr   = grant[1] ? addr1  : addr0;
  assign sel_wdata  = grant[1] ? wdata1 : wdata0;
  assign owner_done = owner_reg ? 2'b10 : 2'b01;

  bus_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state_reg == ST_IDLE),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= 1'b0;
      cmd_reg      <= NOP;
      offset_reg   <= '0;
      wdata_hi_reg <= '0;
      cnt_reg      <= '0;
      done         <= '0;
      err          <= 1'b0;
      rdata        <= '0;
      a1           <= '0;
      c1_out       <= '0;
      c1_oe        <= 1'b0;
      d1_out       <= '0;
      d1_oe        <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            owner_reg    <= grant[1];
            cmd_reg      <= sel_cmd;
            offset_reg   <= sel_addr[OFFSET_W-1:0];
            wdata_hi_reg <= sel_wdata[31:16];
            if (sel_cmd == NOP) begin
              // Illegal command never touches the bus; it is rejected immediately.
              done  <= grant;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state_reg <= ST_ADDR1;
              c1_oe     <= 1'b1;
              c1_out    <= sel_cmd;
              a1        <= A1_W'(sel_addr >> OFFSET_W);
              d1_oe     <= is_write(sel_cmd);
              d1_out    <= sel_wdata[15:0];
            end
          end
        end
        ST_ADDR1: begin
          state_reg <= ST_ADDR2;
          a1        <= A1_W'(offset_reg);
          d1_out    <= wdata_hi_reg;
        end
        ST_ADDR2: begin
          state_reg <= ST_TURN;
          c1_oe     <= 1'b0;
          d1_oe     <= 1'b0;
          c1_out    <= '0;
        end
        ST_TURN: begin
          state_reg <= ST_WAIT_RSP;
          cnt_reg   <= CNT_W'(1);
        end
        ST_WAIT_RSP: begin
          // A response on the timeout cycle itself still counts as a response.
          if (c1_in == C1_RESPONSE) begin
            case (cmd_reg)
              R32: begin
                rdata[15:0] <= d1_in;
                state_reg   <= ST_RSP_HI;
              end
              R8: begin
                rdata     <= {24'b0, d1_in[7:0]};
                done      <= owner_done;
                state_reg <= ST_IDLE;
              end
              R16: begin
                rdata     <= {16'b0, d1_in};
                done      <= owner_done;
                state_reg <= ST_IDLE;
              end
              default: begin
                rdata     <= '0;
                done      <= owner_done;
                state_reg <= ST_IDLE;
              end
            endcase
          end else if ((TIMEOUT != 0) && (cnt_reg == TMO_CNT)) begin
            rdata     <= '0;
            err       <= 1'b1;
            done      <= owner_done;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_RSP_HI: begin
          rdata[31:16] <= d1_in;
          done         <= owner_done;
          state_reg    <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the bus arbiter.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v;
  cmd_t        cmd_v   [2];
  logic [19:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic [14:0] a1;
  logic [2:0]  c1_out;
  logic        c1_oe;
  logic [2:0]  c1_in;
  logic [15:0] d1_out;
  logic        d1_oe;
  logic [15:0] d1_in;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_txn = 0;
  int          ptr_m = 0;
  logic [31:0] last_rd_m = '0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(
    .ADDR_W(20), .OFFSET_W(5), .A1_W(15), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req(req_v),
    .cmd0(cmd_v[0]), .cmd1(cmd_v[1]),
    .addr0(addr_v[0]), .addr1(addr_v[1]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
    .done(done), .err(err), .rdata(rdata), .a1(a1),
    .c1_out(c1_out), .c1_oe(c1_oe), .c1_in(c1_in),
    .d1_out(d1_out), .d1_oe(d1_oe), .d1_in(d1_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction from the current req_v; winner chosen by the round-robin rule.
  // delay = silent WAIT cycles before the response; respond=0 lets it time out.
  task automatic do_txn(input int delay, input bit respond, input logic [15:0] lo,
                        input logic [15:0] hi, input bit withdraw);
    int w, r, last, k;
    cmd_t c;
    logic [19:0] a;
    logic [31:0] d, exp_rd, exp_done;
    bit wr;
    w = (req_v == 2'b11) ? ptr_m : (req_v[1] ? 1 : 0);
    ptr_m = 1 - w;
    c = cmd_v[w];
    a = addr_v[w];
    d = wdata_v[w];
    wr = (c == W8) || (c == W16) || (c == W32);
    exp_done = (w == 1) ? 32'd2 : 32'd1;
    c1_in = 3'd0;
    d1_in = 16'($urandom);
    @(negedge clk);
    if (c == NOP) begin
      chk("nop_done", 32'(done), exp_done);
      chk("nop_err", 32'(err), 32'd1);
      chk("nop_c1_oe", 32'(c1_oe), 32'd0);
      chk("nop_rdata", rdata, 32'd0);
      last_rd_m = '0;
      req_v[w] = 1'b0;
      n_txn++;
      $display("txn %0d: req%0d cmd=%s addr=%h rdata=%h err=%b", n_txn, w, c.name(), a, rdata, err);
      return;
    end
    chk("addr1_done", 32'(done), 32'd0);
    chk("rdata_hold", rdata, last_rd_m);
    chk("addr1_c1_oe", 32'(c1_oe), 32'd1);
    chk("addr1_c1_out", 32'(c1_out), 32'(c));
    chk("addr1_a1", 32'(a1), 32'(a >> 5));
    chk("addr1_d1_oe", 32'(d1_oe), 32'(wr));
    if (wr) chk("addr1_d1_out", 32'(d1_out), 32'(d[15:0]));
    if (withdraw) req_v[w] = 1'b0;
    @(negedge clk);
    chk("addr2_c1_oe", 32'(c1_oe), 32'd1);
    chk("addr2_c1_out", 32'(c1_out), 32'(c));
    chk("addr2_a1", 32'(a1), 32'(a[4:0]));
    chk("addr2_d1_oe", 32'(d1_oe), 32'(wr));
    if (wr) chk("addr2_d1_out", 32'(d1_out), 32'(d[31:16]));
    @(negedge clk);
    chk("turn_c1_oe", 32'(c1_oe), 32'd0);
    chk("turn_d1_oe", 32'(d1_oe), 32'd0);
    chk("turn_a1", 32'(a1), 32'(a[4:0]));
    r = respond ? delay + 1 : 0;
    last = respond ? 4 + r + ((c == R32) ? 1 : 0) : 4 + TMO;
    for (int n = 3; n < last; n++) begin
      k = n - 3;
      if (k == 0) begin
        c1_in = 3'($urandom_range(0, 7));
        d1_in = 16'($urandom);
      end else if (respond && k == r) begin
        c1_in = C1_RESPONSE;
        d1_in = lo;
      end else if (respond && k == r + 1) begin
        c1_in = 3'($urandom_range(0, 7));
        d1_in = hi;
      end else begin
        c1_in = 3'($urandom_range(0, 6));
        d1_in = 16'($urandom);
      end
      @(negedge clk);
      if (n + 1 < last) chk("wait_no_done", 32'(done), 32'd0);
    end
    case (c)
      R8:      exp_rd = {24'b0, lo[7:0]};
      R16:     exp_rd = {16'b0, lo};
      R32:     exp_rd = {hi, lo};
      default: exp_rd = '0;
    endcase
    if (!respond) exp_rd = '0;
    chk("txn_done", 32'(done), exp_done);
    chk("txn_err", 32'(err), respond ? 32'd0 : 32'd1);
    chk("txn_rdata", rdata, exp_rd);
    last_rd_m = exp_rd;
    req_v[w] = 1'b0;
    c1_in = 3'd0;
    n_txn++;
    $display("txn %0d: req%0d cmd=%s addr=%h rdata=%h err=%b", n_txn, w, c.name(), a, rdata, err);
  endtask

  initial begin
    logic [1:0] nr;
    reset = 1'b1;
    req_v = 2'b00;
    c1_in = 3'd0;
    d1_in = 16'd0;
    for (int i = 0; i < 2; i++) begin
      cmd_v[i] = NOP;
      addr_v[i] = '0;
      wdata_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_a1", 32'(a1), 32'd0);
    chk("rst_c1_out", 32'(c1_out), 32'd0);
    chk("rst_c1_oe", 32'(c1_oe), 32'd0);
    chk("rst_d1_out", 32'(d1_out), 32'd0);
    chk("rst_d1_oe", 32'(d1_oe), 32'd0);
    reset = 1'b0;

    // Simultaneous pair from reset: R32 on req0 first, then W32 on req1.
    cmd_v[0] = R32; addr_v[0] = 20'h00A45; wdata_v[0] = 32'h0;
    cmd_v[1] = W32; addr_v[1] = 20'h31F07; wdata_v[1] = 32'hDEADBEEF;
    req_v = 2'b11;
    do_txn(2, 1'b1, 16'h1234, 16'hABCD, 1'b0);
    do_txn(1, 1'b1, 16'h5555, 16'h6666, 1'b0);
    cmd_v[0] = R8; addr_v[0] = 20'h7FFFF;
    req_v = 2'b01;
    do_txn(0, 1'b1, 16'h12C3, 16'h0, 1'b0);
    cmd_v[0] = R16; addr_v[0] = 20'h0001F;
    cmd_v[1] = INV; addr_v[1] = 20'h40020;
    req_v = 2'b11;
    do_txn(3, 1'b1, 16'hBEEF, 16'h0, 1'b0);
    do_txn(0, 1'b1, 16'h8001, 16'h0, 1'b0);

    // Timeout with no response, then a response on exactly the last allowed cycle.
    cmd_v[1] = R16; addr_v[1] = 20'h0ABCD;
    req_v = 2'b10;
    do_txn(0, 1'b0, 16'h0, 16'h0, 1'b0);
    cmd_v[0] = R8; addr_v[0] = 20'h00100;
    req_v = 2'b01;
    do_txn(TMO - 1, 1'b1, 16'h77A5, 16'h0, 1'b0);

    cmd_v[0] = NOP;
    req_v = 2'b01;
    do_txn(0, 1'b1, 16'h0, 16'h0, 1'b0);

    // Reset while waiting for a response, then a contested pair must start from req0.
    cmd_v[0] = R8; addr_v[0] = 20'h12345;
    req_v = 2'b01;
    c1_in = 3'd0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_c1_oe", 32'(c1_oe), 32'd0);
    chk("midrst_d1_oe", 32'(d1_oe), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    req_v = 2'b00;
    ptr_m = 0;
    last_rd_m = '0;
    cmd_v[0] = R8; addr_v[0] = 20'h0F0F0;
    cmd_v[1] = R8; addr_v[1] = 20'h0A0A0;
    req_v = 2'b11;
    do_txn(0, 1'b1, 16'h3C5A, 16'h0, 1'b0);
    do_txn(2, 1'b1, 16'h00FF, 16'h0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      nr = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        if (nr[i] && !req_v[i]) begin
          cmd_v[i] = ($urandom_range(0, 15) == 0) ? NOP : cmd_t'($urandom_range(1, 7));
          addr_v[i] = 20'($urandom);
          wdata_v[i] = $urandom;
        end
      end
      req_v = req_v | nr;
      do_txn($urandom_range(0, TMO - 1), $urandom_range(0, 9) != 0,
             16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
      if (req_v == 2'b00 && $urandom_range(0, 2) == 0) @(negedge clk);
    end

    req_v = 2'b00;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
